// File: rtl/seq_decoder.sv
// -----------------------------------------------------------------------------
// seq_decoder
//
// Pipelined N-to-2^N decoder with valid/ready handshakes on both sides. Each
// accepted select code is decoded once, at input transfer, into an OUT_W-bit
// word. The word is then queued in a two-entry store: a main output register
// and one skid register. The skid lets in_ready be a pure register output while
// still sustaining one word per cycle under a continuously ready sink.
//
// Decode modes (in_mode):
//   2'b00  one-hot      bit s set
//   2'b01  thermometer  bits 0..s set
//   2'b10  one-cold     inverse of one-hot
//   2'b11  accumulate   word = acc | onehot(s), and acc takes the word
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word present
//   in_ready   out  block can accept (registered)
//   in_sel     in   [SEL_W-1:0] select code
//   in_mode    in   [1:0] decode mode
//   clr        in   synchronous clear of the accumulator
//   out_valid  out  output word present (registered)
//   out_ready  in   downstream accepts
//   out_data   out  [OUT_W-1:0] decoded word (registered)
//   out_sel    out  [SEL_W-1:0] select code that produced out_data
//
// SEL_W must be in 1..6. OUT_W = 2**SEL_W is derived and cannot be overridden.
// -----------------------------------------------------------------------------
module seq_decoder #(
  parameter  int SEL_W = 3,
  localparam int OUT_W = 2 ** SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SEL_W-1:0] in_sel,
  input  logic [1:0]       in_mode,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [SEL_W-1:0] out_sel
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing stored
    ST_ONE   = 2'd1,  // main register holds a word, skid empty
    ST_FULL  = 2'd2   // main and skid both hold words
  } state_t;

  localparam logic [1:0] MODE_ONEHOT = 2'b00;
  localparam logic [1:0] MODE_THERMO = 2'b01;
  localparam logic [1:0] MODE_COLD   = 2'b10;
  localparam logic [1:0] MODE_ACC    = 2'b11;

  localparam logic [OUT_W-1:0] LSB_ONE = OUT_W'(1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [OUT_W-1:0]   r_main_data;
  logic [SEL_W-1:0]   r_main_sel;
  logic [OUT_W-1:0]   r_skid_data;
  logic [SEL_W-1:0]   r_skid_sel;
  logic [OUT_W-1:0]   r_acc;

  // ---------------------------------------------------------------------------
  // Wires
  // ---------------------------------------------------------------------------
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic               w_acc_xfer;
  logic [OUT_W-1:0]   w_onehot;
  logic [OUT_W-1:0]   w_thermo;
  logic [OUT_W-1:0]   w_acc_base;
  logic [OUT_W-1:0]   w_word;
  state_t             w_state_nxt;
  logic               w_load_main;
  logic               w_load_skid;
  logic               w_skid_to_main;

  // Handshakes are qualified only by registered ready/valid, so neither
  // out_ready nor in_* reaches the opposite side's outputs combinationally.
  assign w_in_xfer  = in_valid  & r_in_ready;
  assign w_out_xfer = r_out_valid & out_ready;
  assign w_acc_xfer = w_in_xfer & (in_mode == MODE_ACC);

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign w_onehot = LSB_ONE << in_sel;

  // (onehot << 1) - 1 sets bits 0..s. For s = OUT_W-1 the shift wraps to zero
  // and the subtraction underflows to all ones, which is the wanted result.
  assign w_thermo = (w_onehot << 1) - LSB_ONE;

  // A clear in the same cycle as an accumulate transfer takes effect first.
  assign w_acc_base = clr ? '0 : r_acc;

  always_comb begin
    // NOTE: every signal written in a combinational block gets a default
    // before any branch, so no path leaves it unassigned and no latch forms.
    w_word = w_onehot;
    case (in_mode)
      MODE_ONEHOT: w_word = w_onehot;
      MODE_THERMO: w_word = w_thermo;
      MODE_COLD:   w_word = ~w_onehot;
      MODE_ACC:    w_word = w_acc_base | w_onehot;
      default:     w_word = w_onehot;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Storage FSM: next state and datapath steering
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt    = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        case ({w_in_xfer, w_out_xfer})
          2'b11: begin
            // Main drains and refills in the same edge; skid stays unused.
            w_state_nxt = ST_ONE;
            w_load_main = 1'b1;
          end
          2'b10: begin
            w_state_nxt = ST_FULL;
            w_load_skid = 1'b1;
          end
          2'b01: begin
            w_state_nxt = ST_EMPTY;
          end
          default: begin
            w_state_nxt = ST_ONE;
          end
        endcase
      end
      ST_FULL: begin
        // in_ready is low here, so only an output transfer can happen.
        if (w_out_xfer) begin
          w_state_nxt    = ST_ONE;
          w_skid_to_main = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != ST_FULL);
      r_out_valid <= (w_state_nxt != ST_EMPTY);
    end
  end

  // NOTE: the two data entries are reset along with control; they are only
  // two words, and a reset value keeps out_data defined at 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= '0;
      r_main_sel  <= '0;
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else begin
      if (w_load_main) begin
        r_main_data <= w_word;
        r_main_sel  <= in_sel;
      end else if (w_skid_to_main) begin
        r_main_data <= r_skid_data;
        r_main_sel  <= r_skid_sel;
      end
      if (w_load_skid) begin
        r_skid_data <= w_word;
        r_skid_sel  <= in_sel;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Accumulator: moves only on an accumulate transfer or a clear
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_acc_xfer) begin
      r_acc <= w_word;
    end else if (clr) begin
      r_acc <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;

endmodule

// File: tb/tb_seq_decoder.sv
// -----------------------------------------------------------------------------
// tb_seq_decoder
//
// Self-checking bench for seq_decoder (SEL_W = 3). A behavioural model keeps
// the stored words in a queue (at most two entries) and the accumulator as a
// plain vector; ready/valid are derived from the queue depth. Every cycle the
// DUT outputs are compared with the model on the falling edge, and directed
// sections add literal checks for the documented example values.
// -----------------------------------------------------------------------------
module tb_seq_decoder;

  localparam int SEL_W = 3;
  localparam int OUT_W = 2 ** SEL_W;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic [1:0]       in_mode;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [SEL_W-1:0] out_sel;

  seq_decoder #(.SEL_W(SEL_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_mode   (in_mode),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks;
  int n_fails;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [OUT_W-1:0] data;
    logic [SEL_W-1:0] sel;
  } entry_t;

  entry_t           m_q[$];
  logic [OUT_W-1:0] m_acc;

  function automatic logic [OUT_W-1:0] ref_word(input int s, input int m,
                                                input logic [OUT_W-1:0] acc_eff);
    logic [OUT_W-1:0] w;
    w = '0;
    for (int i = 0; i < OUT_W; i++) begin
      case (m)
        0:       w[i] = (i == s);
        1:       w[i] = (i <= s);
        2:       w[i] = (i != s);
        default: w[i] = acc_eff[i] | (i == s);
      endcase
    end
    return w;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_acc = '0;
  endtask

  task automatic check_outputs();
    check("in_ready",  in_ready,  m_q.size() < 2);
    check("out_valid", out_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      check("out_data", out_data, m_q[0].data);
      check("out_sel",  out_sel,  m_q[0].sel);
    end
  endtask

  // One clock cycle: compare outputs on the falling edge, drive inputs, then
  // advance the model at the rising edge from its own ready/valid view.
  task automatic cycle(input logic iv, input int s, input int m, input logic c,
                       input logic ordy);
    logic             in_x;
    logic             out_x;
    logic [OUT_W-1:0] w;
    entry_t           e;
    @(negedge clk);
    check_outputs();
    in_valid  = iv;
    in_sel    = s[SEL_W-1:0];
    in_mode   = m[1:0];
    clr       = c;
    out_ready = ordy;
    @(posedge clk);
    in_x  = iv && (m_q.size() < 2);
    out_x = ordy && (m_q.size() > 0);
    w = ref_word(s, m, c ? '0 : m_acc);
    if (in_x && m == 3) m_acc = w;
    else if (c)         m_acc = '0;
    if (out_x) void'(m_q.pop_front());
    if (in_x) begin
      e.data = w;
      e.sel  = s[SEL_W-1:0];
      m_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 1'b0, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_mode   = '0;
    clr       = 1'b0;
    out_ready = 1'b1;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  8'h00);
    check("rst_out_sel",   out_sel,   3'd0);
    check("rst_in_ready",  in_ready,  1'b1);
    check("rst_acc",       dut.r_acc, 8'h00);
    rst_n = 1'b1;

    // One-hot sweep, back-to-back, sink always ready
    for (int s = 0; s < OUT_W; s++) begin
      cycle(1'b1, s, 0, 1'b0, 1'b1);
      #1;
      check("onehot_data", out_data, 8'h01 << s);
      check("onehot_sel",  out_sel,  s);
      check("onehot_rdy",  in_ready, 1'b1);
    end
    idle(2);

    // Mode coverage
    cycle(1'b1, 5, 1, 1'b0, 1'b1); #1 check("thermo5", out_data, 8'h3F);
    cycle(1'b1, 7, 1, 1'b0, 1'b1); #1 check("thermo7", out_data, 8'hFF);
    cycle(1'b1, 0, 1, 1'b0, 1'b1); #1 check("thermo0", out_data, 8'h01);
    cycle(1'b1, 2, 2, 1'b0, 1'b1); #1 check("cold2",   out_data, 8'hFB);
    idle(2);

    // Accumulate with clear
    cycle(1'b1, 1, 3, 1'b0, 1'b1); #1 check("acc1",     out_data, 8'h02);
    cycle(1'b1, 4, 3, 1'b0, 1'b1); #1 check("acc4",     out_data, 8'h12);
    cycle(1'b1, 6, 3, 1'b0, 1'b1); #1 check("acc6",     out_data, 8'h52);
    cycle(1'b1, 0, 3, 1'b1, 1'b1); #1 check("acc0_clr", out_data, 8'h01);
    cycle(1'b0, 0, 3, 1'b1, 1'b1); #1 check("clr_only", dut.r_acc, 8'h00);
    cycle(1'b1, 3, 3, 1'b0, 1'b1); #1 check("acc3",     out_data, 8'h08);
    idle(2);

    // Back-pressure
    cycle(1'b1, 2, 0, 1'b0, 1'b0); #1 check("bp_rdy1",  in_ready, 1'b1);
    cycle(1'b1, 3, 0, 1'b0, 1'b0); #1 check("bp_rdy2",  in_ready, 1'b0);
    check("bp_data2", out_data, 8'h04);
    cycle(1'b1, 4, 0, 1'b0, 1'b0); #1 check("bp_hold",  out_data, 8'h04);
    check("bp_rdy3", in_ready, 1'b0);
    cycle(1'b1, 4, 0, 1'b0, 1'b1); #1 check("bp_drain1", out_data, 8'h08);
    check("bp_rdy4", in_ready, 1'b1);
    cycle(1'b1, 4, 0, 1'b0, 1'b1); #1 check("bp_drain2", out_data, 8'h10);
    check("bp_rdy5", in_ready, 1'b1);
    idle(3);

    // Random streaming with random back-pressure and occasional clears
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, int'($urandom_range(OUT_W - 1)), int'($urandom_range(3)),
            ($urandom_range(15) == 0), $urandom_range(1) == 1);
    end
    idle(4);
    check("drained", m_q.size(), 0);

    // Reset while FULL with acc = 0x52
    cycle(1'b0, 0, 3, 1'b1, 1'b1);
    cycle(1'b1, 1, 3, 1'b0, 1'b0);
    cycle(1'b1, 4, 3, 1'b0, 1'b1);
    cycle(1'b1, 6, 3, 1'b0, 1'b0);
    #1;
    check("pre_rst_full", in_ready, 1'b0);
    check("pre_rst_acc",  dut.r_acc, 8'h52);
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_ready", in_ready,  1'b1);
    check("mid_rst_acc",   dut.r_acc, 8'h00);
    #1;
    rst_n = 1'b1;
    model_reset();
    idle(2);
    cycle(1'b1, 0, 3, 1'b0, 1'b1); #1 check("post_rst_acc0", out_data, 8'h01);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
